// File: rtl/proc_pkg.sv
// Shared definitions for the processor-side interrupt logic.
//   DATA_W       : datapath / vector width
//   DEF_VEC_BASE : default ISR vector of source 0
//   SEL_W        : width of a source index (up to 8 sources)
//   ic_state_t   : interrupt controller FSM encoding
//   vec_of()     : vector address for a source index (8-bit wrap)
package proc_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam logic [DATA_W-1:0] DEF_VEC_BASE = 8'h01;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'b00,
    IC_REQ     = 2'b01,
    IC_SERVICE = 2'b10
  } ic_state_t;

  function automatic logic [DATA_W-1:0] vec_of(input logic [DATA_W-1:0] base,
                                               input logic [SEL_W-1:0]  idx);
    return base + {{(DATA_W-SEL_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational priority encoder; bit 0 has the highest priority.
//   req   : candidate request bits
//   idx   : index of the lowest set bit (0 when none set)
//   valid : any bit of req set
module irq_priority_enc
  import proc_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller in front of the pipeline's single
// interrupt entry. Rising edges on Irq_In set Pending bits; the lowest
// enabled pending source is requested with a req/ack handshake, and the
// controller stays in service until the pipeline retires RTI.
//   clk        : system clock
//   rst        : async active-low reset
//   Irq_In     : interrupt lines, rising-edge triggered
//   Mask_We    : mask register write strobe
//   Mask_Data  : new mask (1 = enabled)
//   Int_Ack    : pipeline accepted the interrupt
//   Rti        : RTI retired
//   Int_Req    : interrupt request to pipeline control
//   Vector     : ISR address of the selected source
//   In_Service : ack seen, RTI not yet seen
//   Pending    : raw pending bits (unmasked)
//
// state      | meaning
// IC_IDLE    | waiting for an enabled pending source
// IC_REQ     | Int_Req asserted, waiting for Int_Ack
// IC_SERVICE | ISR running, waiting for Rti
module interrupt_controller
  import proc_pkg::*;
#(
  parameter int                N_SRC    = 4,
  parameter logic [DATA_W-1:0] VEC_BASE = DEF_VEC_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  Irq_In,
  input  logic              Mask_We,
  input  logic [N_SRC-1:0]  Mask_Data,
  input  logic              Int_Ack,
  input  logic              Rti,
  output logic              Int_Req,
  output logic [DATA_W-1:0] Vector,
  output logic              In_Service,
  output logic [N_SRC-1:0]  Pending
);

  ic_state_t         state_q, state_d;
  logic [N_SRC-1:0]  prev_q;
  logic              armed_q;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] vec_q;
  logic [N_SRC-1:0]  edge_set;
  logic [N_SRC-1:0]  clr_vec;
  logic              take;
  logic              load_sel;
  logic [SEL_W-1:0]  enc_idx;
  logic              enc_valid;

  // History clears in reset, so a line already high when reset releases
  // would look like a fresh edge. Edge detection is held off for the first
  // clock after release, letting prev_q pick up the real line levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= Irq_In;
      armed_q <= 1'b1;
    end
  end

  assign edge_set = armed_q ? (Irq_In & ~prev_q) : '0;
  assign take     = (state_q == IC_REQ) && Int_Ack;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_vec[i] = take && (sel_q == SEL_W'(i));
    end
  end

  // A new edge on the source being acknowledged wins over its clear.
  assign pend_d = (pend_q & ~clr_vec) | edge_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      mask_q <= '1;
    end else begin
      pend_q <= pend_d;
      if (Mask_We) mask_q <= Mask_Data;
    end
  end

  irq_priority_enc #(
    .N_SRC (N_SRC)
  ) u_enc (
    .req   (pend_q & mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IC_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_sel = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (enc_valid) begin
          state_d  = IC_REQ;
          load_sel = 1'b1;
        end
      end
      IC_REQ: begin
        if (Int_Ack) state_d = IC_SERVICE;
      end
      IC_SERVICE: begin
        if (Rti) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // Selection is frozen from IDLE->REQ until the next arbitration, so mask
  // writes or higher-priority edges never disturb an outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
      vec_q <= '0;
    end else if (load_sel) begin
      sel_q <= enc_idx;
      vec_q <= vec_of(VEC_BASE, enc_idx);
    end
  end

  assign Int_Req    = (state_q == IC_REQ);
  assign In_Service = (state_q == IC_SERVICE);
  assign Vector     = vec_q;
  assign Pending    = pend_q;

endmodule
